// File: rtl/rv_pkg.sv
// Shared LSU definitions: FSM states, RISC-V funct3 codes
// and byte-enable base patterns.
package rv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/rv_lsu_align.sv
// Lane steering for the LSU: byte enables, store replication,
// misalign/illegal detection and load extension.
module rv_lsu_align
  import rv_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        illegal;
  logic        uns;
  logic [7:0]  b;
  logic [15:0] h;

  assign is_b = funct3_i[1:0] == 2'b00;
  assign is_h = funct3_i[1:0] == 2'b01;
  assign is_w = funct3_i[1:0] == 2'b10;
  assign uns  = funct3_i[2];

  // Stores have no unsigned forms, so any funct3[2] is illegal there.
  assign illegal = we_i
    ? (funct3_i[2] | (&funct3_i[1:0]))
    : ((&funct3_i[1:0]) | (funct3_i == 3'b110));

  assign misalign_o = illegal
    | (is_h & addr_i[0])
    | (is_w & (|addr_i));

  assign b = 8'(rdata_i >> {addr_i, 3'b000});
  assign h = 16'(rdata_i >> {addr_i[1], 4'b0000});

  always_comb begin
    be_o    = '0;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    unique case (1'b1)
      is_b: begin
        be_o    = BE_B << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = uns ? {24'b0, b} : {{24{b[7]}}, b};
      end
      is_h: begin
        be_o    = BE_H << {addr_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = uns ? {16'b0, h} : {{16{h[15]}}, h};
      end
      is_w: begin
        be_o = BE_W;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Single-outstanding load/store unit: IDLE/BUS/RESP FSM,
// captured request, bus timeout counter.
module rv_lsu
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  output logic        o_bus_req,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_timeout
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q, cnt_d;

  logic        idle;
  logic        tmo_hit;
  logic [1:0]  al_addr;
  logic [2:0]  al_f3;
  logic        al_we;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_wdo;
  logic [31:0] al_rdata;
  logic        al_mis;

  assign idle = state_q == S_IDLE;

  // Classify the incoming op in IDLE, the held op otherwise.
  assign al_addr  = idle ? i_addr[1:0] : addr_q[1:0];
  assign al_f3    = idle ? i_funct3 : f3_q;
  assign al_we    = idle ? i_we : we_q;
  assign al_wdata = idle ? i_wdata : wdata_q;

  rv_lsu_align u_align (
    .addr_i     (al_addr),
    .funct3_i   (al_f3),
    .we_i       (al_we),
    .wdata_i    (al_wdata),
    .rdata_i    (i_bus_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdo),
    .rdata_o    (al_rdata),
    .misalign_o (al_mis)
  );

  assign tmo_hit = (TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (i_valid) state_d = al_mis ? S_RESP : S_BUS;
      S_BUS:  if (i_bus_ack || tmo_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    mis_d   = mis_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    if (idle && i_valid) begin
      addr_d  = i_addr;
      wdata_d = i_wdata;
      f3_d    = i_funct3;
      we_d    = i_we;
      mis_d   = al_mis;
      to_d    = 1'b0;
      rdata_d = '0;
    end else if (state_q == S_BUS) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      if (i_bus_ack) begin
        rdata_d = we_q ? '0 : al_rdata;
        cnt_d   = '0;
      end else if (tmo_hit) begin
        to_d  = 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    o_ready     = idle;
    o_bus_req   = state_q == S_BUS;
    o_valid     = state_q == S_RESP;
    o_misalign  = o_valid & mis_q;
    o_timeout   = o_valid & to_q;
    o_rdata     = rdata_q;
    o_bus_addr  = {addr_q[31:2], 2'b00};
    o_bus_we    = we_q;
    o_bus_be    = al_be;
    o_bus_wdata = al_wdo;
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized self-checking bench for rv_lsu against a
// transaction-level reference model.
module tb_rv_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [2:0]  i_funct3 = '0;
  logic        i_we = 1'b0;
  logic        o_bus_req;
  logic [31:0] o_bus_addr;
  logic        o_bus_we;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_valid;
  logic [31:0] o_rdata;
  logic        o_misalign;
  logic        o_timeout;

  int n_chk = 0;
  int n_err = 0;

  rv_lsu #(.TIMEOUT(TO)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_funct3    (i_funct3),
    .i_we        (i_we),
    .o_bus_req   (o_bus_req),
    .o_bus_addr  (o_bus_addr),
    .o_bus_we    (o_bus_we),
    .o_bus_be    (o_bus_be),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata),
    .o_valid     (o_valid),
    .o_rdata     (o_rdata),
    .o_misalign  (o_misalign),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_bad(input logic [2:0] f3, input bit we,
                               input logic [31:0] a);
    int f;
    f = int'(f3);
    if (we ? (f > 2) : (f == 3 || f >= 6)) return 1'b1;
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int sz;
    sz = m_size(f3);
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3,
                                       input logic [31:0] w);
    case (m_size(f3))
      1: return {24'b0, w[7:0]} * 32'h0101_0101;
      2: return {16'b0, w[15:0]} * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] r);
    logic [31:0] x;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    x  = r >> (8 * (a % 4));
    sb = x[7:0];
    sh = x[15:0];
    case (int'(f3))
      0: return 32'(int'(sb));
      1: return 32'(int'(sh));
      4: return {24'b0, x[7:0]};
      5: return {16'b0, x[15:0]};
      default: return r;
    endcase
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] w,
                        input logic [2:0] f3, input bit we,
                        input logic [31:0] r, input int d);
    bit bad;
    bit tmo;
    int k;
    int expk;
    bad = m_bad(f3, we, a);
    tmo = !bad && d >= TO;
    expk = bad ? 0 : (tmo ? TO : d + 1);
    k = 0;
    // stray ack while idle must be ignored
    i_bus_ack = 1'($urandom % 2);
    i_bus_rdata = $urandom;
    @(posedge clk); #1;
    i_bus_ack = 1'b0;
    check("idle_ready", 32'(o_ready), 32'd1);
    check("idle_valid", 32'(o_valid), 32'd0);
    i_addr = a; i_wdata = w; i_funct3 = f3; i_we = we;
    i_valid = 1'b1;
    @(posedge clk); #1;
    while (o_bus_req && k < 16) begin
      i_valid = 1'($urandom % 2);
      i_addr = $urandom;
      i_wdata = $urandom;
      i_funct3 = 3'($urandom);
      i_we = 1'($urandom % 2);
      check("bus_addr", o_bus_addr, a & 32'hFFFF_FFFC);
      check("bus_be", 32'(o_bus_be), 32'(m_be(f3, a)));
      check("bus_we", 32'(o_bus_we), 32'(we));
      check("bus_valid", 32'(o_valid), 32'd0);
      if (we) check("bus_wdata", o_bus_wdata, m_wd(f3, w));
      i_bus_ack = (k == d);
      i_bus_rdata = (k == d) ? r : $urandom;
      @(posedge clk); #1;
      k++;
    end
    i_bus_ack = 1'b0;
    i_valid = 1'b0;
    check("latency", 32'(k), 32'(expk));
    check("valid", 32'(o_valid), 32'd1);
    check("misalign", 32'(o_misalign), 32'(bad));
    check("timeout", 32'(o_timeout), 32'(tmo));
    check("rdata", o_rdata,
          (bad || we || tmo) ? 32'd0 : m_ld(f3, a, r));
    @(posedge clk); #1;
    check("post_valid", 32'(o_valid), 32'd0);
    check("post_ready", 32'(o_ready), 32'd1);
  endtask

  initial begin
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_req", 32'(o_bus_req), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_mis", 32'(o_misalign), 32'd0);
    check("rst_to", 32'(o_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(32'h100, 32'h0, 3'b010, 1'b0, 32'hDEADBEEF, 0);
    run_op(32'h103, 32'h0, 3'b000, 1'b0, 32'h80FF_FFFF, 0);
    run_op(32'h103, 32'h0, 3'b100, 1'b0, 32'h80FF_FFFF, 1);
    run_op(32'h002, 32'h1234ABCD, 3'b001, 1'b1, 32'h5555_5555, 0);
    run_op(32'h101, 32'h0, 3'b010, 1'b0, 32'h1111_1111, 0);
    run_op(32'h200, 32'h0, 3'b010, 1'b0, 32'h2222_2222, 100);
    run_op(32'h300, 32'hCAFE, 3'b011, 1'b1, 32'h0, 0);
    run_op(32'h306, 32'h0, 3'b101, 1'b0, 32'hF00D_8001, 2);

    // reset while a request is on the bus
    i_addr = 32'h400; i_funct3 = 3'b010; i_we = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("rb_req", 32'(o_bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rb_req_drop", 32'(o_bus_req), 32'd0);
    check("rb_ready", 32'(o_ready), 32'd1);
    check("rb_valid", 32'(o_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    i_bus_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("ra_valid", 32'(o_valid), 32'd0);
      check("ra_ready", 32'(o_ready), 32'd1);
    end
    i_bus_ack = 1'b0;

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      run_op(a, $urandom, 3'($urandom), 1'($urandom % 2),
             $urandom, int'($urandom % 6));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles o_bus_req stays high without i_bus_ack; 0 disables the timeout.
REQ-002 Clock is i_clk and reset is i_reset_n; there is one clock domain, and reset is asynchronous and active-low.
REQ-003 Port list, one per line: name, direction, width, meaning.
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  execute stage presents a memory op.
- o_ready  out  1  LSU accepts an op this cycle.
- i_addr  in  32  effective address, taken from the ALU result.
- i_wdata  in  32  store data (rs2).
- i_funct3  in  3  RISC-V load/store width/sign code.
- i_we  in  1  1 = store, 0 = load.
- o_bus_req  out  1  bus request.
- o_bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- o_bus_we  out  1  bus write.
- o_bus_be  out  4  byte enables.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_ack  in  1  bus completes the request.
- i_bus_rdata  in  32  read word, valid with i_bus_ack.
- o_valid  out  1  one-cycle completion pulse to writeback.
- o_rdata  out  32  extended load result.
- o_misalign  out  1  misaligned or illegal access, valid with o_valid.
- o_timeout  out  1  bus timeout, valid with o_valid.

Function
REQ-004 The FSM has states IDLE, BUS and RESP; o_ready = (state==IDLE).
REQ-005 In IDLE, i_valid&o_ready captures addr, wdata, funct3 and we at the edge; the FSM then goes to RESP if the op is misaligned/illegal, else to BUS.
REQ-006 Misaligned conditions: halfword with addr[0]=1; word with addr[1:0]!=0. Illegal funct3: loads 011/110/111; stores 011-111. Both conditions set o_misalign, and no bus request is made.
REQ-007 In BUS, o_bus_req=1 and addr/we/be/wdata stay stable until the cycle in which i_bus_ack=1; an ack in the first BUS cycle is legal.
REQ-008 On ack, i_bus_rdata is extended and registered into o_rdata, and the FSM goes to RESP.
REQ-009 In RESP, o_valid=1 for exactly one cycle, then the FSM returns to IDLE; minimum latency is accept edge -> o_valid 2 cycles later.
REQ-010 Byte enables: byte ops 4'b0001<<addr[1:0]; halfword ops 4'b0011<<{addr[1],1'b0}; word ops 4'b1111; loads drive the same enables.
REQ-011 Store data: byte ops replicate {4{wdata[7:0]}}; halfword ops replicate {2{wdata[15:0]}}; word ops pass through unchanged.
REQ-012 Load extraction: select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-013 A 32-bit-safe cycle counter runs in BUS; when TIMEOUT!=0 and the count reaches TIMEOUT with no ack, o_bus_req drops, o_timeout=1 and o_rdata=0 in RESP.
REQ-014 For stores, misalign and timeout cases, o_rdata=0 during RESP.
REQ-015 i_bus_ack outside BUS is ignored; i_valid outside IDLE is ignored and not queued.
REQ-016 o_misalign and o_timeout are 0 whenever o_valid=0.

Reset
REQ-017 On i_reset_n low, asynchronously: state=IDLE, o_bus_req=0, o_valid=0, o_rdata=0, o_misalign=0, o_timeout=0, counter=0; o_ready=1 once reset is asserted.
REQ-018 Reset mid-BUS drops o_bus_req immediately and produces no o_valid for the aborted op.

Structure
REQ-019 Shared package rv_pkg holds the FSM state enum, the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the byte-enable patterns.
REQ-020 One combinational sub-module, rv_lsu_align, computes be, wdata replication, the misalign flag and load extension; rv_lsu holds the FSM, the capture registers and the counter.

Verification
REQ-021 LW at 0x100, ack in first BUS cycle with rdata=0xDEADBEEF -> o_bus_be=4'hF, o_valid 2 cycles after accept, o_rdata=0xDEADBEEF.
REQ-022 LB at 0x103 with rdata=0x80FF_FFFF -> be=4'b1000, o_rdata=0xFFFFFF80; the same access as LBU -> o_rdata=0x00000080.
REQ-023 SH at 0x002 with wdata=0x1234ABCD -> be=4'b1100, o_bus_wdata=0xABCDABCD, o_bus_we=1, o_valid with o_rdata=0.
REQ-024 LW at 0x101 -> no o_bus_req, o_valid with o_misalign=1 in the cycle after accept.
REQ-025 TIMEOUT=4 with ack never asserted -> o_bus_req high 4 cycles, then o_valid with o_timeout=1, o_rdata=0.
REQ-026 Assert i_reset_n low during BUS -> o_bus_req=0 the same cycle, no o_valid, o_ready=1 after release.
